// File: rtl/mipi_dphy_clk_seq_if.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
// Module   : mipi_dphy_clk_seq_if
// Brief    : Control/status bundle between the D-PHY clock sequencer and its
//            PLL instances and downstream domains.
// Revision : 1.0 - initial release
// ============================================================================
interface mipi_dphy_clk_seq_if #(
  parameter int N_PLL   = 2,
  parameter int N_DOM   = 3,
  parameter int RETRY_W = 4
);
  logic               i_pwrdwn_req;
  logic               i_restart;
  logic [N_PLL-1:0]   i_pll_locked;
  logic [N_PLL-1:0]   o_pll_rst;
  logic [N_PLL-1:0]   o_pll_pwrdwn;
  logic [N_DOM-1:0]   o_domain_reset;
  logic               o_ready;
  logic               o_fail;
  logic [RETRY_W-1:0] o_retry_count;
  logic [2:0]         o_state;

  modport master (
    input  i_pwrdwn_req, i_restart, i_pll_locked,
    output o_pll_rst, o_pll_pwrdwn, o_domain_reset, o_ready, o_fail,
           o_retry_count, o_state
  );

  modport slave (
    output i_pwrdwn_req, i_restart, i_pll_locked,
    input  o_pll_rst, o_pll_pwrdwn, o_domain_reset, o_ready, o_fail,
           o_retry_count, o_state
  );
endinterface
`default_nettype wire

// File: rtl/mipi_dphy_clk_seq.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
// Module   : mipi_dphy_clk_seq
// Brief    : PLL reset/power-down sequencer with lock monitoring, bounded
//            retries and ordered release of downstream domain resets.
// Revision : 1.0 - initial release
// ============================================================================
module mipi_dphy_clk_seq #(
  parameter int N_PLL        = 2,
  parameter int N_DOM        = 3,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 64,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int STEP_CYCLES  = 64,
  parameter int MAX_RETRY    = 3,
  parameter int RETRY_W      = 4
) (
  input  wire logic           clk,
  input  wire logic           reset_n,
  mipi_dphy_clk_seq_if.master bus
);

  typedef enum logic [2:0] {
    ST_PWRDN     = 3'd0,
    ST_PLL_RST   = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAIL      = 3'd5
  } state_t;

  localparam int RST_W = $clog2(RST_CYCLES) + 1;
  localparam int TO_W  = $clog2(LOCK_TIMEOUT) + 1;
  localparam int STB_W = $clog2(LOCK_STABLE) + 1;
  localparam int STP_W = $clog2(STEP_CYCLES) + 1;

  localparam logic [RST_W-1:0]   RST_LIM   = RST_W'(RST_CYCLES);
  localparam logic [TO_W-1:0]    TO_LIM    = TO_W'(LOCK_TIMEOUT);
  localparam logic [STB_W-1:0]   STB_LIM   = STB_W'(LOCK_STABLE);
  localparam logic [STP_W-1:0]   STP_LIM   = STP_W'(STEP_CYCLES);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

  state_t             r_state;
  logic [N_PLL-1:0]   r_sync1;
  logic [N_PLL-1:0]   r_sync2;
  logic [RST_W-1:0]   r_rst_cnt;
  logic [TO_W-1:0]    r_to_cnt;
  logic [STB_W-1:0]   r_stb_cnt;
  logic [STP_W-1:0]   r_step_cnt;
  logic               r_pll_rst;
  logic               r_pll_pwrdwn;
  logic [N_DOM-1:0]   r_dom_rst;
  logic               r_ready;
  logic               r_fail;
  logic [RETRY_W-1:0] r_retry;

  logic               w_lock_all;
  logic [RST_W-1:0]   w_rst_nxt;
  logic [TO_W-1:0]    w_to_nxt;
  logic [STB_W-1:0]   w_stb_nxt;
  logic [STP_W-1:0]   w_step_nxt;
  logic               w_stb_done;
  logic               w_timeout;
  logic               w_lock_loss;
  logic [RETRY_W-1:0] w_retry_inc;
  logic               w_retry_exh;

  // Lock outputs come straight from the PLLs with no relation to clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.i_pll_locked;
      r_sync2 <= r_sync1;
    end
  end

  assign w_lock_all  = &r_sync2;
  assign w_rst_nxt   = r_rst_cnt + RST_W'(1);
  assign w_to_nxt    = r_to_cnt + TO_W'(1);
  assign w_step_nxt  = r_step_cnt + STP_W'(1);
  assign w_stb_nxt   = w_lock_all ? (r_stb_cnt + STB_W'(1)) : '0;
  assign w_stb_done  = (r_state == ST_WAIT_LOCK) && w_lock_all && (w_stb_nxt == STB_LIM);
  // Stable completion beats a timeout landing on the same cycle.
  assign w_timeout   = (r_state == ST_WAIT_LOCK) && !w_stb_done && (w_to_nxt == TO_LIM);
  assign w_lock_loss = ((r_state == ST_RELEASE) || (r_state == ST_RUN)) && !w_lock_all;
  assign w_retry_inc = (&r_retry) ? r_retry : (r_retry + RETRY_W'(1));
  assign w_retry_exh = (w_retry_inc >= RETRY_LIM);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_PLL_RST;
      r_pll_rst    <= 1'b1;
      r_pll_pwrdwn <= 1'b0;
      r_dom_rst    <= '1;
      r_ready      <= 1'b0;
      r_fail       <= 1'b0;
      r_retry      <= '0;
      r_rst_cnt    <= '0;
      r_to_cnt     <= '0;
      r_stb_cnt    <= '0;
      r_step_cnt   <= '0;
    end else if (bus.i_pwrdwn_req) begin
      r_state      <= ST_PWRDN;
      r_pll_pwrdwn <= 1'b1;
      r_pll_rst    <= 1'b1;
      r_dom_rst    <= '1;
      r_ready      <= 1'b0;
      r_fail       <= 1'b0;
      r_rst_cnt    <= '0;
    end else if (w_timeout || w_lock_loss) begin
      r_retry   <= w_retry_inc;
      r_pll_rst <= 1'b1;
      r_dom_rst <= '1;
      r_ready   <= 1'b0;
      r_rst_cnt <= '0;
      if (w_retry_exh) begin
        r_state <= ST_FAIL;
        r_fail  <= 1'b1;
      end else begin
        r_state <= ST_PLL_RST;
      end
    end else begin
      case (r_state)
        ST_PWRDN: begin
          r_state      <= ST_PLL_RST;
          r_pll_pwrdwn <= 1'b0;
        end
        ST_PLL_RST: begin
          if (w_rst_nxt == RST_LIM) begin
            r_state   <= ST_WAIT_LOCK;
            r_pll_rst <= 1'b0;
            r_to_cnt  <= '0;
            r_stb_cnt <= '0;
          end else begin
            r_rst_cnt <= w_rst_nxt;
          end
        end
        ST_WAIT_LOCK: begin
          if (w_stb_done) begin
            r_state    <= ST_RELEASE;
            r_dom_rst  <= r_dom_rst << 1;
            r_step_cnt <= '0;
          end else begin
            r_to_cnt  <= w_to_nxt;
            r_stb_cnt <= w_stb_nxt;
          end
        end
        // Domain resets clear LSB first by shifting zeros in from the bottom.
        ST_RELEASE: begin
          if (w_step_nxt == STP_LIM) begin
            r_step_cnt <= '0;
            if (r_dom_rst == '0) begin
              r_state <= ST_RUN;
              r_ready <= 1'b1;
              r_retry <= '0;
            end else begin
              r_dom_rst <= r_dom_rst << 1;
            end
          end else begin
            r_step_cnt <= w_step_nxt;
          end
        end
        ST_RUN: begin
          r_ready <= 1'b1;
        end
        ST_FAIL: begin
          if (bus.i_restart) begin
            r_state   <= ST_PLL_RST;
            r_fail    <= 1'b0;
            r_retry   <= '0;
            r_rst_cnt <= '0;
          end
        end
        default: begin
          r_state   <= ST_PLL_RST;
          r_pll_rst <= 1'b1;
          r_dom_rst <= '1;
          r_ready   <= 1'b0;
          r_fail    <= 1'b0;
          r_rst_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.o_pll_rst      = {N_PLL{r_pll_rst}};
  assign bus.o_pll_pwrdwn   = {N_PLL{r_pll_pwrdwn}};
  assign bus.o_domain_reset = r_dom_rst;
  assign bus.o_ready        = r_ready;
  assign bus.o_fail         = r_fail;
  assign bus.o_retry_count  = r_retry;
  assign bus.o_state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mipi_dphy_clk_seq.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
// Module   : tb_mipi_dphy_clk_seq
// Brief    : Scoreboard bench for the clock sequencer; PLL locks follow the
//            PLL reset like a real PLL, gated by bench-controlled masks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mipi_dphy_clk_seq;

  typedef struct {
    int          cyc;
    logic [15:0] v;
    string       nm;
  } ev_t;

  logic        clk;
  logic        reset_n;
  logic [1:0]  lock_mask;
  logic        glitch_en;
  logic        glitch_low;
  int          gcnt;
  int          cyc;
  int          n_cmp;
  int          n_bad;
  ev_t         exp_q[$];
  logic [15:0] prev;

  mipi_dphy_clk_seq_if #(.N_PLL(2), .N_DOM(3), .RETRY_W(4)) bus ();

  mipi_dphy_clk_seq #(
    .N_PLL(2), .N_DOM(3), .RST_CYCLES(4), .LOCK_STABLE(8), .LOCK_TIMEOUT(100),
    .STEP_CYCLES(5), .MAX_RETRY(3), .RETRY_W(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc   = 0;
    n_cmp = 0;
    n_bad = 0;
    prev  = '1;
    gcnt  = 0;
    glitch_low = 1'b0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // A locked PLL drops lock while held in reset; PLL 0 can be made glitchy.
  assign bus.i_pll_locked = {2{~bus.o_pll_rst[0]}} & lock_mask & ~{1'b0, glitch_low};

  always @(negedge clk) begin
    if (glitch_en) begin
      gcnt       = (gcnt == 5) ? 0 : gcnt + 1;
      glitch_low = (gcnt == 0);
    end else begin
      gcnt       = 0;
      glitch_low = 1'b0;
    end
  end

  function automatic logic [15:0] pk(input logic [2:0] st, input logic prst, input logic ppd,
                                     input logic [2:0] dom, input logic rdy, input logic fl,
                                     input logic [3:0] rc);
    return {st, {2{prst}}, {2{ppd}}, dom, rdy, fl, rc};
  endfunction

  // Monitor: any change of the output vector is an event to be matched.
  always @(negedge clk) begin
    logic [15:0] w;
    ev_t e;
    w = {bus.o_state, bus.o_pll_rst, bus.o_pll_pwrdwn, bus.o_domain_reset,
         bus.o_ready, bus.o_fail, bus.o_retry_count};
    if (w !== prev) begin
      prev = w;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event cyc=%0d got=%h want=none", cyc, w);
      end else begin
        e = exp_q.pop_front();
        if ((e.v !== w) || (e.cyc != cyc)) begin
          n_bad++;
          $display("FAIL %s got cyc=%0d val=%h want cyc=%0d val=%h", e.nm, cyc, w, e.cyc, e.v);
        end
      end
    end
  end

  task automatic ex(input int c, input string nm, input logic [15:0] v);
    ev_t e;
    e.cyc = c;
    e.v   = v;
    e.nm  = nm;
    exp_q.push_back(e);
  endtask

  // From PLL_RST entry at edge e: 4 reset cycles, 2 sync + 8 stable, 3 x 5 steps.
  task automatic seq_events(input int e, input logic [3:0] rc);
    ex(e + 4,  "wait_lock",  pk(3'd2, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, rc));
    ex(e + 14, "release_d0", pk(3'd3, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0, rc));
    ex(e + 19, "release_d1", pk(3'd3, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0, rc));
    ex(e + 24, "release_d2", pk(3'd3, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, rc));
    ex(e + 29, "run",        pk(3'd4, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 4'd0));
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_drain(input int maxc);
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < maxc)) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout got pending=%0d want=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  initial begin
    int b, c, r, p, q;
    reset_n          = 1'b0;
    lock_mask        = 2'b11;
    glitch_en        = 1'b0;
    bus.i_pwrdwn_req = 1'b0;
    bus.i_restart    = 1'b0;

    // Power-on
    ex(1, "reset_state", pk(3'd1, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 4'd0));
    wait_cyc(3);
    reset_n = 1'b1;
    b = cyc;
    seq_events(b, 4'd0);
    wait_drain(200);

    // Lock loss in RUN
    c = cyc;
    lock_mask = 2'b01;
    ex(c + 3, "lock_loss", pk(3'd1, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 4'd1));
    seq_events(c + 3, 4'd1);
    @(negedge clk);
    lock_mask = 2'b11;
    wait_drain(200);

    // Asynchronous reset pulse mid-RUN, then power-down during RELEASE
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    r = cyc;
    ex(r, "async_reset", pk(3'd1, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 4'd0));
    ex(r + 4,  "wait_lock_ar", pk(3'd2, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 4'd0));
    ex(r + 14, "release_ar",   pk(3'd3, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0, 4'd0));
    #0.5;
    chk("async_dom_rst", {13'd0, bus.o_domain_reset}, 16'h0007);
    chk("async_ready",   {15'd0, bus.o_ready},        16'h0000);
    chk("async_state",   {13'd0, bus.o_state},        16'h0001);
    #0.5;
    reset_n = 1'b1;
    wait_cyc(r + 15);
    bus.i_pwrdwn_req = 1'b1;
    ex(r + 16, "pwrdn", pk(3'd0, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 4'd0));
    wait_cyc(r + 18);
    bus.i_pwrdwn_req = 1'b0;
    ex(r + 19, "pwrdn_exit", pk(3'd1, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 4'd0));
    seq_events(r + 19, 4'd0);
    wait_drain(200);

    // Glitchy lock times out once, then no lock at all until FAIL
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    p = cyc;
    glitch_en = 1'b1;
    ex(p, "reset_glitch", pk(3'd1, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 4'd0));
    wait_cyc(p + 3);
    reset_n = 1'b1;
    q = cyc;
    ex(q + 4,   "wait_glitch",  pk(3'd2, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 4'd0));
    ex(q + 104, "timeout_1",    pk(3'd1, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 4'd1));
    ex(q + 108, "wait_nolock1", pk(3'd2, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 4'd1));
    ex(q + 208, "timeout_2",    pk(3'd1, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 4'd2));
    ex(q + 212, "wait_nolock2", pk(3'd2, 1'b0, 1'b0, 3'b111, 1'b0, 1'b0, 4'd2));
    ex(q + 312, "fail_state",   pk(3'd5, 1'b1, 1'b0, 3'b111, 1'b0, 1'b1, 4'd3));
    wait_cyc(q + 105);
    glitch_en = 1'b0;
    lock_mask = 2'b00;
    wait_cyc(q + 315);
    lock_mask     = 2'b11;
    bus.i_restart = 1'b1;
    ex(q + 316, "restart", pk(3'd1, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 4'd0));
    seq_events(q + 316, 4'd0);
    @(negedge clk);
    bus.i_restart = 1'b0;
    wait_drain(400);

    // Restart outside FAIL must not disturb RUN
    bus.i_restart = 1'b1;
    @(negedge clk);
    bus.i_restart = 1'b0;
    repeat (10) @(negedge clk);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_events got=%0d want=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
